// File: rtl/bus_port_buffer.sv
// Per-port buffer between a device and the bus arbiter: TX FIFO toward the bus,
// RX FIFO capturing bus deliveries addressed to this port.

module bus_port_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [W-1:0]               din,
    input  logic                       rd,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       not_empty,
    output logic                       wr_drop
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  mem [0:DEPTH-1];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          wr_ok, rd_ok;

    // A write into a full FIFO is accepted only when the head leaves on the same edge.
    assign wr_ok   = wr && (!full || rd);
    assign rd_ok   = rd && not_empty;
    assign wr_drop = wr && full && !rd;
    assign dout    = not_empty ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_EMPTY;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (wr_ok)
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            if (rd_ok)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= din;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: begin
                if (wr_ok)
                    state_nxt = S_PARTIAL;
            end
            S_PARTIAL: begin
                if (wr_ok && !rd_ok && count == CNT_LAST)
                    state_nxt = S_FULL;
                else if (rd_ok && !wr_ok && count == CNT_ONE)
                    state_nxt = S_EMPTY;
            end
            S_FULL: begin
                if (rd_ok && !wr_ok)
                    state_nxt = S_PARTIAL;
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        full      = 1'b0;
        not_empty = 1'b0;
        case (state)
            S_PARTIAL: not_empty = 1'b1;
            S_FULL: begin
                full      = 1'b1;
                not_empty = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

module bus_port_buffer #(
    parameter int pckg_sz   = 32,
    parameter int fifo_size = 8,
    parameter int port_id   = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           dev_wr,
    input  logic [pckg_sz-1:0]             dev_din,
    output logic                           dev_full,
    input  logic                           dev_rd,
    output logic [pckg_sz-1:0]             dev_dout,
    output logic                           dev_valid,
    output logic                           pndng,
    output logic [pckg_sz-1:0]             D_pop,
    input  logic                           pop,
    input  logic                           push,
    input  logic [pckg_sz-1:0]             D_push,
    output logic [$clog2(fifo_size+1)-1:0] tx_count,
    output logic [$clog2(fifo_size+1)-1:0] rx_count,
    output logic [7:0]                     tx_ovf,
    output logic [7:0]                     rx_drop
);
    localparam logic [7:0] PORT_ID = 8'(port_id);

    logic id_match, rx_wr, rx_full, rx_wr_drop, rx_drop_ev;
    logic tx_wr_drop;

    assign id_match   = (D_push[pckg_sz-1 -: 8] == PORT_ID);
    assign rx_wr      = push && id_match;
    assign rx_drop_ev = push && (!id_match || rx_wr_drop);

    bus_port_fifo #(.W(pckg_sz), .DEPTH(fifo_size)) u_tx (
        .clk       (clk),
        .rst       (reset),
        .wr        (dev_wr),
        .din       (dev_din),
        .rd        (pop),
        .dout      (D_pop),
        .count     (tx_count),
        .full      (dev_full),
        .not_empty (pndng),
        .wr_drop   (tx_wr_drop)
    );

    bus_port_fifo #(.W(pckg_sz), .DEPTH(fifo_size)) u_rx (
        .clk       (clk),
        .rst       (reset),
        .wr        (rx_wr),
        .din       (D_push),
        .rd        (dev_rd),
        .dout      (dev_dout),
        .count     (rx_count),
        .full      (rx_full),
        .not_empty (dev_valid),
        .wr_drop   (rx_wr_drop)
    );

    // Drop counters saturate and only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_ovf  <= '0;
            rx_drop <= '0;
        end else begin
            if (tx_wr_drop && tx_ovf != 8'hFF)
                tx_ovf <= tx_ovf + 8'd1;
            if (rx_drop_ev && rx_drop != 8'hFF)
                rx_drop <= rx_drop + 8'd1;
        end
    end

    logic unused_rx_full;
    assign unused_rx_full = rx_full;
endmodule

// File: tb/tb_bus_port_buffer.sv
// Directed bench for bus_port_buffer with queue scoreboards for TX and RX order.

module tb_bus_port_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        dev_wr, dev_rd, pop, push;
    logic [31:0] dev_din, D_push;
    logic        dev_full, dev_valid, pndng;
    logic [31:0] dev_dout, D_pop;
    logic [3:0]  tx_count, rx_count;
    logic [7:0]  tx_ovf, rx_drop;

    int checks = 0;
    int errors = 0;
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic [31:0] v;

    bus_port_buffer #(.pckg_sz(32), .fifo_size(8), .port_id(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .dev_wr    (dev_wr),
        .dev_din   (dev_din),
        .dev_full  (dev_full),
        .dev_rd    (dev_rd),
        .dev_dout  (dev_dout),
        .dev_valid (dev_valid),
        .pndng     (pndng),
        .D_pop     (D_pop),
        .pop       (pop),
        .push      (push),
        .D_push    (D_push),
        .tx_count  (tx_count),
        .rx_count  (rx_count),
        .tx_ovf    (tx_ovf),
        .rx_drop   (rx_drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; dev_wr = 0; dev_rd = 0; pop = 0; push = 0;
        dev_din = '0; D_push = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_pndng", 32'(pndng), 0);
        chk("rst_dpop", D_pop, 0);
        chk("rst_txcnt", 32'(tx_count), 0);
        chk("rst_full", 32'(dev_full), 0);
        chk("rst_valid", 32'(dev_valid), 0);
        chk("rst_ovf", 32'(tx_ovf), 0);
        chk("rst_rxdrop", 32'(rx_drop), 0);

        // single write then pop
        dev_wr = 1; dev_din = 32'h0100AA55; tx_q.push_back(dev_din);
        tick();
        dev_wr = 0;
        chk("wr1_pndng", 32'(pndng), 1);
        chk("wr1_dpop", D_pop, 32'h0100AA55);
        pop = 1;
        v = tx_q.pop_front();
        chk("pop1_head", D_pop, v);
        tick();
        pop = 0;
        chk("pop1_pndng", 32'(pndng), 0);
        chk("pop1_dpop", D_pop, 0);

        // pop while empty
        pop = 1;
        tick();
        pop = 0;
        chk("pop_empty_cnt", 32'(tx_count), 0);

        // fill, then overflow
        for (int i = 0; i < 8; i++) begin
            dev_wr = 1; dev_din = 32'h01000000 + 32'(i); tx_q.push_back(dev_din);
            tick();
        end
        dev_wr = 0;
        chk("fill_full", 32'(dev_full), 1);
        chk("fill_cnt", 32'(tx_count), 8);
        chk("fill_ovf0", 32'(tx_ovf), 0);
        dev_wr = 1; dev_din = 32'h01DEAD00;
        tick();
        dev_wr = 0;
        chk("ovf1", 32'(tx_ovf), 1);
        chk("ovf1_head", D_pop, tx_q[0]);
        chk("ovf1_cnt", 32'(tx_count), 8);

        // simultaneous write+pop while full, with wrap-around
        for (int i = 0; i < 20; i++) begin
            dev_wr = 1; pop = 1; dev_din = 32'h01000100 + 32'(i);
            v = tx_q.pop_front();
            chk("full_rw_head", D_pop, v);
            tx_q.push_back(dev_din);
            tick();
            chk("full_rw_cnt", 32'(tx_count), 8);
            chk("full_rw_ovf", 32'(tx_ovf), 1);
        end
        dev_wr = 0; pop = 0;

        dev_wr = 1; dev_din = 32'h01BAD000;
        repeat (300) tick();
        dev_wr = 0;
        chk("ovf_sat", 32'(tx_ovf), 255);
        chk("ovf_sat_cnt", 32'(tx_count), 8);
        chk("ovf_sat_head", D_pop, tx_q[0]);

        for (int i = 0; i < 8; i++) begin
            pop = 1;
            v = tx_q.pop_front();
            chk("drain_head", D_pop, v);
            tick();
        end
        pop = 0;
        chk("drain_pndng", 32'(pndng), 0);
        chk("drain_dpop", D_pop, 0);
        chk("drain_cnt", 32'(tx_count), 0);
        chk("drain_full", 32'(dev_full), 0);

        // simultaneous write+pop while empty
        dev_wr = 1; pop = 1; dev_din = 32'h0100BEEF; tx_q.push_back(dev_din);
        tick();
        dev_wr = 0; pop = 0;
        chk("empty_rw_cnt", 32'(tx_count), 1);
        chk("empty_rw_pndng", 32'(pndng), 1);
        chk("empty_rw_head", D_pop, 32'h0100BEEF);
        pop = 1;
        v = tx_q.pop_front();
        chk("empty_rw_pop", D_pop, v);
        tick();
        pop = 0;

        // reset mid-stream acts without a clock edge
        for (int i = 0; i < 3; i++) begin
            dev_wr = 1; dev_din = 32'h01000A00 + 32'(i);
            tick();
        end
        dev_wr = 0;
        chk("mid_cnt3", 32'(tx_count), 3);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_cnt", 32'(tx_count), 0);
        chk("mid_rst_pndng", 32'(pndng), 0);
        chk("mid_rst_dpop", D_pop, 0);
        chk("mid_rst_ovf", 32'(tx_ovf), 0);
        tick();
        reset = 1'b0;

        // RX path, port_id = 2
        push = 1; D_push = 32'h02000011; rx_q.push_back(D_push);
        tick();
        push = 0;
        chk("rx1_valid", 32'(dev_valid), 1);
        chk("rx1_dout", dev_dout, 32'h02000011);
        chk("rx1_cnt", 32'(rx_count), 1);
        push = 1; D_push = 32'h03000022;
        tick();
        push = 0;
        chk("rx_badid_drop", 32'(rx_drop), 1);
        chk("rx_badid_cnt", 32'(rx_count), 1);

        for (int i = 0; i < 7; i++) begin
            push = 1; D_push = 32'h02000100 + 32'(i); rx_q.push_back(D_push);
            tick();
        end
        push = 0;
        chk("rx_full_cnt", 32'(rx_count), 8);
        push = 1; D_push = 32'h02000999;
        tick();
        push = 0;
        chk("rx_full_drop", 32'(rx_drop), 2);
        chk("rx_full_head", dev_dout, rx_q[0]);

        for (int i = 0; i < 3; i++) begin
            push = 1; dev_rd = 1; D_push = 32'h02000A00 + 32'(i);
            v = rx_q.pop_front();
            chk("rx_full_rw_head", dev_dout, v);
            rx_q.push_back(D_push);
            tick();
            chk("rx_full_rw_cnt", 32'(rx_count), 8);
            chk("rx_full_rw_drop", 32'(rx_drop), 2);
        end
        push = 0; dev_rd = 0;

        for (int i = 0; i < 8; i++) begin
            dev_rd = 1;
            v = rx_q.pop_front();
            chk("rx_drain_head", dev_dout, v);
            tick();
        end
        dev_rd = 0;
        chk("rx_drain_valid", 32'(dev_valid), 0);
        chk("rx_drain_dout", dev_dout, 0);
        chk("rx_drain_cnt", 32'(rx_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_port_buffer.md
Name: bus_port_buffer

Overview:
- Per-device interface buffer placed between one device/driver port and the `bs_gnrtr_n_rbtr` bus arbiter.
- TX FIFO holds device packets and presents them to the bus through `pndng` / `D_pop`, drained by the bus `pop`.
- RX FIFO captures bus deliveries (`push` / `D_push`) addressed to this port and offers them to the device.
- One instance per bus port; packet format is the bus format: upper 8 bits = destination ID, remaining bits = payload.

Parameters:
- `pckg_sz`, 32, packet width in bits (minimum 16).
- `fifo_size`, 8, depth of each FIFO in packets (minimum 2; need not be a power of 2).
- `port_id`, 0, this port's bus ID; compared against the destination field of received packets.

Ports:
- `clk`  in  1  single system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dev_wr`  in  1  device writes `dev_din` into the TX FIFO.
- `dev_din`  in  `pckg_sz`  packet from the device.
- `dev_full`  out  1  TX FIFO full.
- `dev_rd`  in  1  device pops the RX FIFO head.
- `dev_dout`  out  `pckg_sz`  RX FIFO head (show-ahead).
- `dev_valid`  out  1  RX FIFO not empty.
- `pndng`  out  1  TX FIFO not empty (request to bus).
- `D_pop`  out  `pckg_sz`  TX FIFO head (show-ahead) to bus.
- `pop`  in  1  bus consumes the TX head this cycle.
- `push`  in  1  bus delivers `D_push` this cycle.
- `D_push`  in  `pckg_sz`  packet from bus.
- `tx_count`  out  `$clog2(fifo_size+1)`  TX occupancy.
- `rx_count`  out  `$clog2(fifo_size+1)`  RX occupancy.
- `tx_ovf`  out  8  TX writes dropped because full; saturates at 255.
- `rx_drop`  out  8  RX packets dropped (full or wrong ID); saturates at 255.

Behaviour:

Reset (asynchronous assert, synchronous-safe deassert):
- Pointers, counts, `tx_ovf`, `rx_drop` = 0; `pndng` = 0, `dev_valid` = 0, `dev_full` = 0.
- `D_pop` and `dev_dout` = 0. Memory is not cleared.
- Reset mid-operation discards all stored packets immediately; no pop/push is honoured while `reset` = 1.

Head presentation:
- Both FIFOs are show-ahead: `D_pop` = `mem_tx[rd_ptr]` when non-empty, else 0. `dev_dout` likewise.
- No combinational path from `pop`/`dev_rd` to `D_pop`/`dev_dout` within the same cycle.

Write latency:
- A packet accepted at edge N makes `pndng` / `dev_valid` high after edge N; the first pop is possible at edge N+1.
- Flags are derived from the registered count: full = (count == `fifo_size`), empty = (count == 0).

Pointers:
- Each pointer increments modulo `fifo_size` with explicit wrap (`fifo_size`-1 -> 0).

TX rules, evaluated each edge:
- `pop` while empty: ignored, no state change.
- `dev_wr` while not full: write at `wr_ptr`, count +1.
- `dev_wr` while full and no `pop`: packet dropped, `tx_ovf` +1 (saturating).
- `dev_wr` and `pop` while full: both accepted; count stays `fifo_size`; no overflow.
- `dev_wr` and `pop` while empty: write accepted; pop ignored; count = 1.
- `dev_wr` and `pop` otherwise: both accepted; count unchanged.

RX rules:
- `push` with `D_push[pckg_sz-1 -: 8]` != `port_id`: dropped, `rx_drop` +1.
- `push` with matching ID: follows the same full/empty/simultaneous rules as TX, with `dev_rd` as the pop side. A full RX FIFO without `dev_rd` drops the packet and `rx_drop` +1.
- If `push` and `dev_rd` occur on the same edge with the FIFO full and a matching ID, both are accepted.
- A broadcast ID is not supported; non-matching packets are always dropped.

Counters:
- `tx_ovf` and `rx_drop` hold at 255 and clear only on reset.

Internal state machine per FIFO: EMPTY / PARTIAL / FULL, driven by the net occupancy change (+1, 0, -1):
- EMPTY -> PARTIAL on accepted write (`fifo_size` > 1).
- PARTIAL -> FULL when count reaches `fifo_size`.
- FULL -> PARTIAL on a pop without a write.
- PARTIAL -> EMPTY when count reaches 0.
- Outputs `pndng`, `dev_full` and `dev_valid` are decoded from this state.

Test Plan:
- Reset then idle: `pndng`=0, `D_pop`=0, `tx_count`=0, `dev_full`=0. Assert `reset` mid-stream after 3 writes -> `tx_count`=0 and `pndng`=0 immediately, without waiting for a clock edge.
- Write 0x01_00AA55 at edge N -> `pndng`=1 and `D_pop`=0x0100AA55 after N. `pop` at N+1 -> `pndng`=0 and `D_pop`=0.
- 8 writes 0x...00..0x...07, then a 9th write with no pop -> `dev_full`=1, `tx_ovf`=1, and `D_pop` still holds the first packet. 300 further writes while full -> `tx_ovf`=255.
- Full FIFO with `dev_wr` and `pop` on the same edge -> `tx_count` stays 8 and `tx_ovf` unchanged. Continue for 20 cycles -> wrap-around order preserved, data pops in write sequence.
- `port_id`=2: `push` `D_push`=0x02_000011 -> `dev_valid`=1, `dev_dout`=0x02000011. `push` `D_push`=0x03_000022 -> `rx_drop`=1 and `rx_count` unchanged.
- Empty TX with `dev_wr` and `pop` on the same edge -> `tx_count`=1, `pndng`=1, and the packet is not lost.
